// File: rtl/inst_queue.sv
// Fetch-to-decode instruction buffer: a DEPTH-entry FIFO of {pc, inst} pairs.
// Flush drops all buffered entries on a redirect; storage contents are left intact.
module inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INST_W-1:0]        out_inst,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [INST_W-1:0] inst_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic              push, pop;

  // Handshakes depend on registered occupancy only; a same-cycle pop never frees a slot.
  assign in_ready  = (count_q != CountFull);
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_q[rd_ptr_q];
  assign out_inst  = inst_q[rd_ptr_q];
  assign count_o   = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]   = in_pc;
        inst_d[wr_ptr_q] = in_inst;
        wr_ptr_d         = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic, checked by a
// queue-based reference model that a negedge monitor compares against the DUT outputs.
module tb_inst_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic [2:0]        count_o;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  ent_t        model[$];

  inst_queue #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .out_ready(out_ready),
    .count_o  (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: compare mid-cycle, then predict the effect of the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      model.delete();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      check("out_valid", 64'(out_valid), 64'(model.size() != 0));
      check("count_o", 64'(count_o), 64'(model.size()));
      check("in_ready", 64'(in_ready), 64'(model.size() < DEPTH));
      if (model.size() != 0) begin
        check("out_pc", out_pc, model[0].pc);
        check("out_inst", 64'(out_inst), 64'(model[0].inst));
      end
      if (flush) begin
        model.delete();
      end else begin
        bit push_ok, pop_ok;
        push_ok = in_valid && (model.size() < DEPTH);
        pop_ok  = out_ready && (model.size() != 0);
        if (pop_ok) void'(model.pop_front());
        if (push_ok) model.push_back('{pc: in_pc, inst: in_inst});
      end
    end
  end

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Fill with decode stalled, then a fifth push that must be refused.
    for (int k = 0; k < 4; k++) drive(1'b1, 64'(4 * k), 32'h13 + 32'(k * 32'h80), 1'b0, 1'b0);
    drive(1'b1, 64'h10, 32'h213, 1'b0, 1'b0);
    drive(1'b1, 64'h10, 32'h213, 1'b0, 1'b0);
    // Drain.
    for (int k = 0; k < 6; k++) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Steady stream.
    for (int k = 0; k < 20; k++) drive(1'b1, 64'h100 + 64'(4 * k), 32'(k), 1'b1, 1'b0);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Flush with simultaneous push and pop at count 3.
    for (int k = 0; k < 3; k++) drive(1'b1, 64'h180 + 64'(4 * k), 32'h55, 1'b0, 1'b0);
    drive(1'b1, 64'h200, 32'hdead, 1'b1, 1'b1);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Full + pop + push: rejected first, accepted next cycle.
    for (int k = 0; k < 4; k++) drive(1'b1, 64'h300 + 64'(4 * k), 32'h77, 1'b0, 1'b0);
    drive(1'b1, 64'h310, 32'h99, 1'b1, 1'b0);
    drive(1'b1, 64'h310, 32'h99, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-run with count 3.
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_count", 64'(count_o), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_out_pc", out_pc, 64'd0);
    check("async_out_inst", 64'(out_inst), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
